counter_cmd_sequencer: RTL

Upstream command stage for the 4-bit loadable up/down counter. It accepts high-level commands (load value, count up N cycles, count down N cycles) over a valid/ready handshake and buffers them in a small FIFO. It expands each command into the cycle-by-cycle `load`, `up_down` and `data_in` controls the counter samples on `posedge clk`. It replaces bench-driven per-cycle stimulus with a synthesizable, back-pressured command path.

---
 rtl/counter_cmd_sequencer_pkg.sv | 30 +++
 rtl/counter_cmd_sequencer_if.sv | 13 +
 rtl/counter_cmd_sequencer_fifo.sv | 54 +++++
 rtl/counter_cmd_sequencer.sv | 97 +++++++++
 4 files changed

// File: rtl/counter_cmd_sequencer_pkg.sv
// Shared types for the counter command sequencer: command encoding, FSM states
// and the FIFO element layout.
package counter_seq_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_UP   = 2'b10,
    OP_DOWN = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN
  } seq_state_e;

  typedef struct packed {
    cmd_op_e          op;
    logic [CNT_W-1:0] arg;
  } cmd_t;

  // An UP/DOWN count of zero stands for the full 2**CNT_W cycles.
  function automatic logic [CNT_W:0] run_len(input logic [CNT_W-1:0] arg);
    return (arg == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, arg};
  endfunction

endpackage

// File: rtl/counter_cmd_sequencer_if.sv
// Command handshake between an upstream source and the sequencer.
interface counter_cmd_sequencer_if;
  import counter_seq_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  cmd_op_e          cmd_op;
  logic [CNT_W-1:0] cmd_arg;

  modport master (output cmd_valid, cmd_op, cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_arg, output cmd_ready);

endinterface

// File: rtl/counter_cmd_sequencer_fifo.sv
// Small synchronous FIFO for queued commands; push is ignored when full and
// pop is ignored when empty, with no write-to-read bypass.
module counter_cmd_fifo
  import counter_seq_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = cmd_t
) (
  input  logic clk,
  input  logic rstn,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output T     rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign rdata  = r_mem[r_rptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end

endmodule

// File: rtl/counter_cmd_sequencer.sv
// Expands queued LOAD/UP/DOWN commands into per-cycle counter controls.
// Outputs are registered one cycle behind the FSM state that produces them.
module counter_cmd_sequencer
  import counter_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  counter_cmd_sequencer_if.slave  cmd,
  output logic                    load,
  output logic                    up_down,
  output logic [CNT_W-1:0]        data_in,
  output logic                    busy,
  output logic                    cmd_done
);

  seq_state_e       r_state, w_state_nxt;
  logic [CNT_W:0]   r_remain, w_remain_nxt;
  logic             r_dir, w_dir_nxt;
  logic [CNT_W-1:0] r_arg, w_arg_nxt;
  cmd_t             w_head;
  cmd_t             w_wdata;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_take;

  assign w_wdata.op    = cmd.cmd_op;
  assign w_wdata.arg   = cmd.cmd_arg;
  assign cmd.cmd_ready = !w_full;

  counter_cmd_fifo #(.DEPTH(DEPTH), .T(cmd_t)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (cmd.cmd_valid),
    .wdata (w_wdata),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  // A new command may start from IDLE or from the final cycle of the current
  // one, which is what removes the bubble between queued commands.
  always_comb begin
    w_state_nxt  = r_state;
    w_remain_nxt = r_remain;
    w_dir_nxt    = r_dir;
    w_arg_nxt    = r_arg;
    w_pop        = 1'b0;
    w_take       = (r_state == ST_IDLE) || (r_state == ST_LOAD) ||
                   ((r_state == ST_RUN) && (r_remain == (CNT_W+1)'(1)));
    if (r_state == ST_RUN) w_remain_nxt = r_remain - 1'b1;
    if (w_take) begin
      w_state_nxt = ST_IDLE;
      if (!w_empty) begin
        w_pop     = 1'b1;
        w_arg_nxt = w_head.arg;
        case (w_head.op)
          OP_LOAD: w_state_nxt = ST_LOAD;
          OP_UP, OP_DOWN: begin
            w_state_nxt  = ST_RUN;
            w_remain_nxt = run_len(w_head.arg);
            w_dir_nxt    = (w_head.op == OP_UP);
          end
          default: w_state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_remain <= '0;
      r_dir    <= 1'b1;
      r_arg    <= '0;
      load     <= 1'b0;
      up_down  <= 1'b1;
      data_in  <= '0;
      cmd_done <= 1'b0;
      busy     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_remain <= w_remain_nxt;
      r_dir    <= w_dir_nxt;
      r_arg    <= w_arg_nxt;
      load     <= (r_state == ST_LOAD);
      cmd_done <= (r_state != ST_IDLE) && w_take;
      busy     <= (r_state != ST_IDLE) || !w_empty;
      if (r_state == ST_LOAD) data_in <= r_arg;
      if (r_state == ST_RUN)  up_down <= r_dir;
    end
  end

endmodule
